// File: rtl/ulpi_link.sv
// rtl/ulpi_link.sv - link-side ULPI controller: bus turnaround, RX CMD/data decode, TX CMD packets, PHY register writes
//
// Optional feature macro: ULPI_REG_READ_EN (adds REG_RD/REG_RDATA and PHY register reads).
//
// Ports:
//   USB_CLKIN, RST               60 MHz PHY clock, synchronous active-high reset
//   ULPI_DATA_I/O/OE             USB_DATA sample, registered drive value, output enable
//   ULPI_DIR, ULPI_NXT           PHY bus ownership and throttle
//   ULPI_STP                     registered stop
//   TX_DATA/TX_VALID/TX_READY    transmit byte stream (first byte is the PID)
//   TX_ABORT                     one-cycle pulse when the PHY takes the bus mid-transmit
//   RX_DATA/RX_VALID             received byte and strobe
//   RX_ACTIVE/RX_ERROR/LINESTATE receive status decoded from RX CMD
//   REG_REQ/REG_ADDR/REG_WDATA   register write request (level until REG_DONE)
//   REG_DONE                     one-cycle completion pulse
//   REG_RD/REG_RDATA             read select and read data (ULPI_REG_READ_EN only)

module ulpi_link (
  input  logic       USB_CLKIN,
  input  logic       RST,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  output logic       ULPI_STP,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_ABORT,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ACTIVE,
  output logic       RX_ERROR,
  output logic [1:0] LINESTATE,
  input  logic       REG_REQ,
  input  logic [5:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  output logic       REG_DONE
`ifdef ULPI_REG_READ_EN
  ,
  input  logic       REG_RD,
  output logic [7:0] REG_RDATA
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TX_CMD   = 4'd1,
    S_TX_DATA  = 4'd2,
    S_TX_STP   = 4'd3,
    S_REG_CMD  = 4'd4,
    S_REG_DATA = 4'd5,
    S_REG_STP  = 4'd6
`ifdef ULPI_REG_READ_EN
    ,
    S_RD_CMD   = 4'd7,
    S_RD_WAIT  = 4'd8
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       oe_q, oe_d;
  logic [7:0] data_o_q, data_o_d;
  logic       stp_q, stp_d;
  logic       tx_abort_q, tx_abort_d;
  logic       reg_done_q, reg_done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_active_q, rx_active_d;
  logic       rx_error_q, rx_error_d;
  logic [1:0] linestate_q, linestate_d;
  logic       tx_ready;
  logic       bus_free;
  logic       req_ok;
  logic       rx_en;
`ifdef ULPI_REG_READ_EN
  logic [7:0] rdata_q, rdata_d;
`endif

  assign bus_free = !ULPI_DIR && !dir_q;
  // REG_DONE is still visible to upstream in the cycle it drops REG_REQ;
  // ignore the stale level then so the write is not issued twice.
  assign req_ok   = REG_REQ && !reg_done_q;

`ifdef ULPI_REG_READ_EN
  // Read data returning during RD_WAIT must not be decoded as an RX CMD.
  assign rx_en = (state_q != S_RD_WAIT);
`else
  assign rx_en = 1'b1;
`endif

  // Transmit / register FSM
  always_comb begin
    state_d    = state_q;
    data_o_d   = data_o_q;
    stp_d      = 1'b0;
    oe_d       = 1'b1;
    tx_ready   = 1'b0;
    tx_abort_d = 1'b0;
    reg_done_d = 1'b0;
`ifdef ULPI_REG_READ_EN
    rdata_d    = rdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        data_o_d = 8'h00;
        if (bus_free) begin
          if (req_ok) begin
`ifdef ULPI_REG_READ_EN
            if (REG_RD) begin
              data_o_d = {2'b11, REG_ADDR};
              state_d  = S_RD_CMD;
            end else begin
              data_o_d = {2'b10, REG_ADDR};
              state_d  = S_REG_CMD;
            end
`else
            data_o_d = {2'b10, REG_ADDR};
            state_d  = S_REG_CMD;
`endif
          end else if (TX_VALID) begin
            tx_ready = 1'b1;
            data_o_d = {4'h4, TX_DATA[3:0]};
            state_d  = S_TX_CMD;
          end
        end
      end
      S_TX_CMD, S_TX_DATA: begin
        if (ULPI_DIR) begin
          tx_abort_d = 1'b1;
          data_o_d   = 8'h00;
          state_d    = S_IDLE;
        end else begin
          tx_ready = ULPI_NXT && TX_VALID;
          if (ULPI_NXT) begin
            if (TX_VALID) begin
              data_o_d = TX_DATA;
              state_d  = S_TX_DATA;
            end else begin
              data_o_d = 8'h00;
              stp_d    = 1'b1;
              state_d  = S_TX_STP;
            end
          end
        end
      end
      S_TX_STP: begin
        state_d = S_IDLE;
      end
      S_REG_CMD: begin
        if (ULPI_DIR) begin
          data_o_d = 8'h00;
          state_d  = S_IDLE;
        end else if (ULPI_NXT) begin
          data_o_d = REG_WDATA;
          state_d  = S_REG_DATA;
        end
      end
      S_REG_DATA: begin
        if (ULPI_DIR) begin
          data_o_d = 8'h00;
          state_d  = S_IDLE;
        end else if (ULPI_NXT) begin
          data_o_d = 8'h00;
          stp_d    = 1'b1;
          state_d  = S_REG_STP;
        end
      end
      S_REG_STP: begin
        reg_done_d = 1'b1;
        state_d    = S_IDLE;
      end
`ifdef ULPI_REG_READ_EN
      S_RD_CMD: begin
        if (ULPI_DIR) begin
          data_o_d = 8'h00;
          state_d  = S_IDLE;
        end else if (ULPI_NXT) begin
          data_o_d = 8'h00;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // First DIR-high cycle is turnaround; data is valid once dir_q follows.
        if (ULPI_DIR && dir_q) begin
          rdata_d    = ULPI_DATA_I;
          reg_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
`endif
      default: begin
        data_o_d = 8'h00;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Receive path
  always_comb begin
    dir_d       = ULPI_DIR;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_active_d = rx_active_q;
    rx_error_d  = rx_error_q;
    linestate_d = linestate_q;
    if (ULPI_DIR && dir_q && rx_en) begin
      if (ULPI_NXT) begin
        rx_data_d  = ULPI_DATA_I;
        rx_valid_d = 1'b1;
      end else begin
        linestate_d = ULPI_DATA_I[1:0];
        case (ULPI_DATA_I[5:4])
          2'b01: begin
            rx_active_d = 1'b1;
            rx_error_d  = 1'b0;
          end
          2'b11: begin
            rx_active_d = 1'b1;
            rx_error_d  = 1'b1;
          end
          default: begin
            rx_active_d = 1'b0;
            rx_error_d  = 1'b0;
          end
        endcase
      end
    end else if (ULPI_DIR && !dir_q && ULPI_NXT) begin
      // PHY grabbed the bus with NXT: a packet starts right after turnaround.
      rx_active_d = 1'b1;
    end else if (!ULPI_DIR && dir_q) begin
      rx_active_d = 1'b0;
      rx_error_d  = 1'b0;
    end
  end

  always_ff @(posedge USB_CLKIN) begin
    if (RST) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      oe_q        <= 1'b0;
      data_o_q    <= 8'h00;
      stp_q       <= 1'b1;
      tx_abort_q  <= 1'b0;
      reg_done_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
      linestate_q <= 2'b00;
`ifdef ULPI_REG_READ_EN
      rdata_q     <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      oe_q        <= oe_d;
      data_o_q    <= data_o_d;
      stp_q       <= stp_d;
      tx_abort_q  <= tx_abort_d;
      reg_done_q  <= reg_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_error_q  <= rx_error_d;
      linestate_q <= linestate_d;
`ifdef ULPI_REG_READ_EN
      rdata_q     <= rdata_d;
`endif
    end
  end

  // OE drops combinationally on DIR so the link never fights the PHY.
  assign ULPI_DATA_OE = oe_q && !ULPI_DIR && !dir_q;
  assign ULPI_DATA_O  = data_o_q;
  assign ULPI_STP     = stp_q;
  assign TX_READY     = tx_ready;
  assign TX_ABORT     = tx_abort_q;
  assign RX_DATA      = rx_data_q;
  assign RX_VALID     = rx_valid_q;
  assign RX_ACTIVE    = rx_active_q;
  assign RX_ERROR     = rx_error_q;
  assign LINESTATE    = linestate_q;
  assign REG_DONE     = reg_done_q;
`ifdef ULPI_REG_READ_EN
  assign REG_RDATA    = rdata_q;
`endif

endmodule

// File: tb/tb_ulpi_link.sv
// tb/tb_ulpi_link.sv - directed self-checking bench for ulpi_link

module tb_ulpi_link;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       data_oe;
  logic       dir;
  logic       nxt;
  logic       stp;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_abort;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic [1:0] linestate;
  logic       reg_req;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_done;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt;

  always #5 clk = ~clk;

  ulpi_link dut (
    .USB_CLKIN   (clk),
    .RST         (rst),
    .ULPI_DATA_I (data_i),
    .ULPI_DATA_O (data_o),
    .ULPI_DATA_OE(data_oe),
    .ULPI_DIR    (dir),
    .ULPI_NXT    (nxt),
    .ULPI_STP    (stp),
    .TX_DATA     (tx_data),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .TX_ABORT    (tx_abort),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .RX_ACTIVE   (rx_active),
    .RX_ERROR    (rx_error),
    .LINESTATE   (linestate),
    .REG_REQ     (reg_req),
    .REG_ADDR    (reg_addr),
    .REG_WDATA   (reg_wdata),
    .REG_DONE    (reg_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; #1 later all outputs are settled.
  task automatic fall();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; data_i = 8'h00; dir = 1'b0; nxt = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    reg_req = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;

    // Reset state
    fall(); fall(); #1;
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_oe", {7'd0, data_oe}, 8'h00);
    chk("rst_stp", {7'd0, stp}, 8'h01);
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'h00);
    chk("rst_tx_abort", {7'd0, tx_abort}, 8'h00);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("rst_rx_active", {7'd0, rx_active}, 8'h00);
    chk("rst_rx_error", {7'd0, rx_error}, 8'h00);
    chk("rst_linestate", {6'd0, linestate}, 8'h00);
    chk("rst_reg_done", {7'd0, reg_done}, 8'h00);
    fall(); rst = 1'b0;
    fall(); #1;
    chk("post_rst_stp", {7'd0, stp}, 8'h00);
    chk("post_rst_oe", {7'd0, data_oe}, 8'h01);

    // Register write 0x0A <= 0x55
    fall(); reg_req = 1'b1; reg_addr = 6'h0A; reg_wdata = 8'h55; nxt = 1'b0; #1;
    chk("wr_idle_ready", {7'd0, tx_ready}, 8'h00);
    fall(); nxt = 1'b1; #1;
    chk("wr_cmd_byte", data_o, 8'h8A);
    chk("wr_cmd_oe", {7'd0, data_oe}, 8'h01);
    chk("wr_cmd_stp", {7'd0, stp}, 8'h00);
    fall(); nxt = 1'b1; #1;
    chk("wr_data_byte", data_o, 8'h55);
    chk("wr_data_oe", {7'd0, data_oe}, 8'h01);
    fall(); nxt = 1'b0; #1;
    chk("wr_stp_byte", data_o, 8'h00);
    chk("wr_stp", {7'd0, stp}, 8'h01);
    chk("wr_stp_oe", {7'd0, data_oe}, 8'h01);
    chk("wr_done_early", {7'd0, reg_done}, 8'h00);
    fall(); #1;
    chk("wr_done", {7'd0, reg_done}, 8'h01);
    chk("wr_done_stp", {7'd0, stp}, 8'h00);
    reg_req = 1'b0;
    fall(); #1;
    chk("wr_done_pulse", {7'd0, reg_done}, 8'h00);
    chk("wr_no_reissue", data_o, 8'h00);

    // TX packet C3 11 22
    ready_cnt = 0;
    fall(); tx_valid = 1'b1; tx_data = 8'hC3; nxt = 1'b1; #1;
    chk("tx_pid_ready", {7'd0, tx_ready}, 8'h01);
    ready_cnt += int'(tx_ready);
    fall(); tx_data = 8'h11; #1;
    chk("tx_cmd_byte", data_o, 8'h43);
    ready_cnt += int'(tx_ready);
    fall(); tx_data = 8'h22; #1;
    chk("tx_b1", data_o, 8'h11);
    ready_cnt += int'(tx_ready);
    fall(); tx_valid = 1'b0; #1;
    chk("tx_b2", data_o, 8'h22);
    ready_cnt += int'(tx_ready);
    fall(); #1;
    chk("tx_stp_byte", data_o, 8'h00);
    chk("tx_stp", {7'd0, stp}, 8'h01);
    ready_cnt += int'(tx_ready);
    chk("tx_ready_cnt", 8'(ready_cnt), 8'd3);
    fall(); nxt = 1'b0; #1;
    chk("tx_stp_clear", {7'd0, stp}, 8'h00);

    // RX: DIR rises with NXT, two bytes, two RX CMDs, DIR falls
    fall(); dir = 1'b1; nxt = 1'b1; #1;
    chk("rx_turn_oe", {7'd0, data_oe}, 8'h00);
    fall(); data_i = 8'hA5; #1;
    chk("rx_active_turn", {7'd0, rx_active}, 8'h01);
    chk("rx_valid_turn", {7'd0, rx_valid}, 8'h00);
    fall(); data_i = 8'h3C; #1;
    chk("rx_valid_a5", {7'd0, rx_valid}, 8'h01);
    chk("rx_data_a5", rx_data, 8'hA5);
    fall(); data_i = 8'h12; nxt = 1'b0; #1;
    chk("rx_valid_3c", {7'd0, rx_valid}, 8'h01);
    chk("rx_data_3c", rx_data, 8'h3C);
    fall(); data_i = 8'h31; #1;
    chk("rx_cmd1_ls", {6'd0, linestate}, 8'h02);
    chk("rx_cmd1_active", {7'd0, rx_active}, 8'h01);
    chk("rx_cmd1_err", {7'd0, rx_error}, 8'h00);
    chk("rx_cmd1_valid", {7'd0, rx_valid}, 8'h00);
    fall(); dir = 1'b0; data_i = 8'h00; #1;
    chk("rx_cmd2_ls", {6'd0, linestate}, 8'h01);
    chk("rx_cmd2_err", {7'd0, rx_error}, 8'h01);
    chk("rx_fall_oe", {7'd0, data_oe}, 8'h00);
    fall(); #1;
    chk("rx_fall_active", {7'd0, rx_active}, 8'h00);
    chk("rx_fall_err", {7'd0, rx_error}, 8'h00);
    chk("rx_fall_ls", {6'd0, linestate}, 8'h01);
    chk("rx_free_oe", {7'd0, data_oe}, 8'h01);

    // PHY abort during TX_DATA
    fall(); tx_valid = 1'b1; tx_data = 8'h5A; nxt = 1'b1; #1;
    fall(); tx_data = 8'h77; #1;
    chk("ab_cmd_byte", data_o, 8'h4A);
    fall(); dir = 1'b1; nxt = 1'b0; #1;
    chk("ab_data_byte", data_o, 8'h77);
    chk("ab_oe_now", {7'd0, data_oe}, 8'h00);
    chk("ab_ready", {7'd0, tx_ready}, 8'h00);
    fall(); tx_valid = 1'b0; #1;
    chk("ab_pulse", {7'd0, tx_abort}, 8'h01);
    fall(); dir = 1'b0; #1;
    chk("ab_pulse_end", {7'd0, tx_abort}, 8'h00);
    fall(); #1;
    fall(); #1;
    chk("ab_idle_oe", {7'd0, data_oe}, 8'h01);
    chk("ab_idle_byte", data_o, 8'h00);

    // REG_REQ and TX_VALID together: write first, then TX CMD
    fall(); reg_req = 1'b1; reg_addr = 6'h01; reg_wdata = 8'h99;
    tx_valid = 1'b1; tx_data = 8'hD2; nxt = 1'b1; #1;
    chk("pri_idle_ready", {7'd0, tx_ready}, 8'h00);
    fall(); #1;
    chk("pri_cmd_byte", data_o, 8'h81);
    chk("pri_cmd_ready", {7'd0, tx_ready}, 8'h00);
    fall(); #1;
    chk("pri_data_byte", data_o, 8'h99);
    chk("pri_data_ready", {7'd0, tx_ready}, 8'h00);
    fall(); #1;
    chk("pri_stp", {7'd0, stp}, 8'h01);
    chk("pri_stp_ready", {7'd0, tx_ready}, 8'h00);
    fall(); reg_req = 1'b0; #1;
    chk("pri_done", {7'd0, reg_done}, 8'h01);
    chk("pri_tx_start", {7'd0, tx_ready}, 8'h01);
    fall(); tx_valid = 1'b0; #1;
    chk("pri_tx_cmd", data_o, 8'h42);
    fall(); #1;
    chk("pri_tx_stp", {7'd0, stp}, 8'h01);
    fall(); #1;

    // RST mid TX_DATA
    fall(); tx_valid = 1'b1; tx_data = 8'h69; nxt = 1'b1; #1;
    fall(); tx_data = 8'hAB; #1;
    fall(); rst = 1'b1; #1;
    chk("mrst_pre_byte", data_o, 8'hAB);
    fall(); rst = 1'b0; tx_valid = 1'b0; nxt = 1'b0; #1;
    chk("mrst_stp", {7'd0, stp}, 8'h01);
    chk("mrst_oe", {7'd0, data_oe}, 8'h00);
    chk("mrst_byte", data_o, 8'h00);
    chk("mrst_ready", {7'd0, tx_ready}, 8'h00);
    chk("mrst_abort", {7'd0, tx_abort}, 8'h00);
    chk("mrst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("mrst_done", {7'd0, reg_done}, 8'h00);
    fall(); #1;
    chk("mrst_stp_clear", {7'd0, stp}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_link.md
# ulpi_link

Link-side ULPI controller between the audio card's 60 MHz ULPI PHY pins (USB_DATA/DIR/NXT/STP) and the USB function core. It owns the bidirectional data bus turnaround and converts the PHY's RX CMD and data stream into a byte-wide receive interface with line state. It also serialises core transmit packets as ULPI TX CMD + data and performs PHY register writes. It sits directly behind the top-level USB pins and feeds the usbf core.

## Interface
Parameters: none.

Ports (clock and reset first):
- USB_CLKIN  in  1  60 MHz clock from the PHY; the only clock.
- RST  in  1  synchronous reset, active-high.
- ULPI_DATA_I  in  8  sampled USB_DATA.
- ULPI_DATA_O  out  8  registered value driven onto USB_DATA.
- ULPI_DATA_OE  out  1  USB_DATA output enable.
- ULPI_DIR  in  1  PHY bus ownership.
- ULPI_NXT  in  1  PHY throttle/next.
- ULPI_STP  out  1  registered stop.
- TX_DATA  in  8  transmit byte; the first byte of a packet is the PID.
- TX_VALID  in  1  transmit byte valid; held high for the whole packet.
- TX_READY  out  1  byte accepted this cycle (combinational).
- TX_ABORT  out  1  one-cycle pulse when the PHY aborts a transmit.
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  one-cycle strobe for RX_DATA.
- RX_ACTIVE  out  1  receive in progress.
- RX_ERROR  out  1  RxError reported by the PHY.
- LINESTATE  out  2  last line state reported by the PHY.
- REG_REQ  in  1  register write request; level, held until REG_DONE.
- REG_ADDR  in  6  register address.
- REG_WDATA  in  8  register write data.
- REG_DONE  out  1  one-cycle completion pulse.

## Operation
- dir_q is ULPI_DIR registered. The bus is free when ULPI_DIR=0 and dir_q=0.
- ULPI_DATA_OE=0 whenever ULPI_DIR=1 or dir_q=1. The turnaround cycle after either edge of DIR is never driven or sampled as data.
- Receive: when ULPI_DIR=1 and dir_q=1:
  - NXT=1: RX_DATA<=ULPI_DATA_I, RX_VALID=1.
  - NXT=0 (RX CMD): LINESTATE<=data[1:0]; data[5:4] decodes 01 as RX_ACTIVE=1/RX_ERROR=0, 11 as RX_ACTIVE=1/RX_ERROR=1, 00 or 10 as RX_ACTIVE=0.
- DIR rising with NXT=1 in the same cycle sets RX_ACTIVE=1 immediately.
- DIR falling clears RX_ACTIVE and RX_ERROR.
- TX FSM states: IDLE, TX_CMD, TX_DATA, TX_STP, REG_CMD, REG_DATA, REG_STP.
- IDLE drives 0x00 (NOOP) when OE=1. When the bus is free:
  - REG_REQ has priority: load 0x80|REG_ADDR and go to REG_CMD.
  - Otherwise, if TX_VALID: TX_READY=1, load 0x40|TX_DATA[3:0], and go to TX_CMD.
- TX_CMD/TX_DATA: TX_READY=NXT&TX_VALID&!DIR.
  - NXT=1 with TX_VALID=1: load TX_DATA and go to TX_DATA.
  - NXT=1 with TX_VALID=0: load 0x00, STP=1, and go to TX_STP.
  - NXT=0: hold the current byte.
- TX_STP: STP=0 and go to IDLE.
- REG_CMD:
  - NXT=1: load REG_WDATA and go to REG_DATA.
- REG_DATA:
  - NXT=1: load 0x00, STP=1, and go to REG_STP.
- REG_STP: REG_DONE=1, STP=0, and go to IDLE.
- Abort: ULPI_DIR=1 in any TX_* or REG_* state returns the FSM to IDLE and releases the bus.
  - In TX_* states, TX_ABORT pulses and upstream must drop TX_VALID before the next packet.
  - In REG_* states, the request stays pending and retries from REG_CMD once the bus is free.
- TX_STP and REG_STP complete regardless of DIR.

## Timing
- Reset values:
  - ULPI_DATA_O=0x00, ULPI_DATA_OE=0, ULPI_STP=1.
  - TX_READY=0, TX_ABORT=0, RX_VALID=0, RX_ACTIVE=0, RX_ERROR=0, LINESTATE=2'b00, REG_DONE=0.
  - FSM=IDLE, dir_q=0.
- The first cycle after RST deasserts drives STP=0.
- RST asserted mid-operation returns everything to reset values on the next edge; no STP sequence is generated beyond STP=1.
- All ULPI outputs are registered. A byte loaded on edge n is on the bus in cycle n+1, and is held until NXT is sampled high.
- RX latency: pin to RX_DATA/RX_VALID is 1 cycle.
- Register write, minimum time from REG_REQ to REG_DONE with NXT tied high: 4 cycles (IDLE, REG_CMD, REG_DATA, REG_STP).
- Simultaneous REG_REQ and TX_VALID in IDLE: the register write wins and TX_READY stays 0.

## Configuration
- ULPI_REG_READ_EN defined:
  - Adds ports REG_RD (in, 1) and REG_RDATA (out, 8), plus states RD_CMD and RD_WAIT.
  - REG_RD with REG_REQ drives 0xC0|REG_ADDR. After NXT=1, the block waits for DIR high, skips the turnaround, and latches REG_RDATA from the next cycle's data. REG_DONE pulses on the same edge that latches REG_RDATA.
  - DIR rising with NXT=1 during RD_CMD counts as an abort, and the read retries.
- Undefined: the extra ports and states are absent and only writes exist.

## Test plan
- Register write, addr 0x0A, data 0x55, NXT high in the cycle after each byte appears -> bus shows 0x8A, then 0x55, then 0x00 with STP=1; REG_DONE one cycle later; OE=1 throughout.
- TX packet PID 0xC3 then 0x11, 0x22, NXT always 1 -> bus 0x43, 0x11, 0x22, 0x00+STP; TX_READY asserted for exactly 3 cycles.
- RX: DIR↑ with NXT=1, then bytes 0xA5, 0x3C with NXT=1, an RX CMD 0x01, then DIR↓ -> RX_ACTIVE=1 from the turnaround; RX_VALID strobes 0xA5 and 0x3C; LINESTATE=01; RX_ACTIVE=0 after DIR↓.
- PHY abort: DIR↑ during TX_DATA -> TX_ABORT one pulse, OE=0 in the same cycle DIR is seen, FSM back to IDLE.
- REG_REQ and TX_VALID raised together -> register write completes first, then TX CMD 0x4x starts.
- RST pulsed mid-TX_DATA -> STP=1, OE=0, all strobes 0 on the next edge.
